ssd_scan_driver: RTL and testbench



---
 rtl/ssd_pkg.sv | 27 ++
 rtl/ssd_symbol_decoder.sv | 30 +++
 rtl/ssd_scan_driver.sv | 120 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared symbol codes and active-low segment patterns for the seven-segment display path
package ssd_pkg;

    localparam logic [3:0] CODE_A     = 4'd10;
    localparam logic [3:0] CODE_M     = 4'd11;
    localparam logic [3:0] CODE_S     = 4'd12;
    localparam logic [3:0] CODE_BLANK = 4'd13;
    localparam logic [3:0] CODE_MINUS = 4'd15;

    // Segment patterns are {a,b,c,d,e,f,g}, active-low; the decimal point is appended by the driver
    localparam logic [6:0] SS_0     = 7'b0000001;
    localparam logic [6:0] SS_1     = 7'b1001111;
    localparam logic [6:0] SS_2     = 7'b0010010;
    localparam logic [6:0] SS_3     = 7'b0000110;
    localparam logic [6:0] SS_4     = 7'b1001100;
    localparam logic [6:0] SS_5     = 7'b0100100;
    localparam logic [6:0] SS_6     = 7'b0100000;
    localparam logic [6:0] SS_7     = 7'b0001111;
    localparam logic [6:0] SS_8     = 7'b0000000;
    localparam logic [6:0] SS_9     = 7'b0000100;
    localparam logic [6:0] SS_A     = 7'b0001000;
    localparam logic [6:0] SS_M     = 7'b0001001;
    localparam logic [6:0] SS_S     = 7'b0100100;
    localparam logic [6:0] SS_MINUS = 7'b1111110;
    localparam logic [6:0] SS_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_symbol_decoder.sv
// ssd_symbol_decoder: combinational 4-bit symbol code to active-low segment lookup
module ssd_symbol_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Codes 13, 14 and anything unlisted render blank
    always_comb begin
        case (code_i)
            4'd0:       seg_o = SS_0;
            4'd1:       seg_o = SS_1;
            4'd2:       seg_o = SS_2;
            4'd3:       seg_o = SS_3;
            4'd4:       seg_o = SS_4;
            4'd5:       seg_o = SS_5;
            4'd6:       seg_o = SS_6;
            4'd7:       seg_o = SS_7;
            4'd8:       seg_o = SS_8;
            4'd9:       seg_o = SS_9;
            CODE_A:     seg_o = SS_A;
            CODE_M:     seg_o = SS_M;
            CODE_S:     seg_o = SS_S;
            CODE_MINUS: seg_o = SS_MINUS;
            default:    seg_o = SS_BLANK;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: tear-free, leading-zero-blanking, time-multiplexed common-anode scan driver
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_en,
    output logic [7:0]            ssd_ctl,
    output logic [DIGITS-1:0]     ssd_an,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d, shad_q, shad_d;
    logic [DIGITS-1:0]     ddp_q, ddp_d, sdp_q, sdp_d;
    logic                  pend_q, pend_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [7:0]            ctl_q, ctl_d;
    logic                  wrap, boundary, run;
    logic [DIGITS-1:0]     lz;
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic [6:0]            cur_seg;

    assign wrap     = presc_q == PW'(REFRESH_DIV - 1);
    assign boundary = wrap && idx_q == IW'(DIGITS - 1);

    // Prescaler wraps every REFRESH_DIV cycles and steps the scan index on each wrap
    always_comb begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = !wrap ? idx_q : boundary ? '0 : idx_q + 1'b1;
    end

    // Loads land in the shadow frame; the display frame only changes at a frame boundary
    always_comb begin
        shad_d = load ? digits_in : shad_q;
        sdp_d  = load ? dp_in : sdp_q;
        disp_d = disp_q;
        ddp_d  = ddp_q;
        pend_d = pend_q;
        if (boundary && load) begin
            disp_d = digits_in;
            ddp_d  = dp_in;
            pend_d = 1'b0;
        end else if (boundary) begin
            disp_d = pend_q ? shad_q : disp_q;
            ddp_d  = pend_q ? sdp_q : ddp_q;
            pend_d = 1'b0;
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    // Blank zero digits from the most significant end until the first non-zero; digit 0 always shows
    always_comb begin
        lz  = '0;
        run = LZ_SUPPRESS != 0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run   = run && disp_q[4*i +: 4] == 4'd0;
            lz[i] = run;
        end
    end

    assign cur_code = lz[idx_q] ? CODE_BLANK : disp_q[4*idx_q +: 4];
    assign cur_dp   = ddp_q[idx_q];

    ssd_symbol_decoder u_dec (
        .code_i (cur_code),
        .seg_o  (cur_seg)
    );

    // Anode and segment values computed together so the registered pins switch on the same edge
    always_comb begin
        for (int i = 0; i < DIGITS; i++) an_d[i] = blank_en || idx_q != IW'(i);
        ctl_d = {cur_seg, ~cur_dp};
    end

    // State and output registers; reset discards any pending frame and darkens the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= {DIGITS{CODE_BLANK}};
            shad_q  <= {DIGITS{CODE_BLANK}};
            ddp_q   <= '0;
            sdp_q   <= '0;
            pend_q  <= 1'b0;
            an_q    <= '1;
            ctl_q   <= 8'hFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            shad_q  <= shad_d;
            ddp_q   <= ddp_d;
            sdp_q   <= sdp_d;
            pend_q  <= pend_d;
            an_q    <= an_d;
            ctl_q   <= ctl_d;
        end
    end

    assign ssd_an     = an_q;
    assign ssd_ctl    = ctl_q;
    assign frame_tick = boundary;
    assign pending    = pend_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench for the four-digit scan driver with a fast refresh divider
module tb_ssd_scan_driver;

    localparam int D  = 4;
    localparam int RD = 4;

    typedef struct {
        logic [3:0] an;
        logic [7:0] ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        blank_en = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [7:0]  ssd_ctl;
    logic [3:0]  ssd_an;
    logic        frame_tick;
    logic        pending;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic [3:0] obs_an[D];
    logic [7:0] obs_ctl[D];

    ssd_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .LZ_SUPPRESS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_en   (blank_en),
        .ssd_ctl    (ssd_ctl),
        .ssd_an     (ssd_an),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // Expected pin values for one full frame, digit 0 first
    task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] c[D];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < D; k++) sb.push_back('{an: ~(4'b0001 << k), ctl: c[k]});
    endtask

    // Returns at the falling edge inside the next frame_tick cycle
    task automatic wait_tick(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = frame_tick;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s tick: frame_tick=0 after 40 cycles, required 1", name);
        end
    endtask

    // Sample the middle of each scan slot of the frame following a tick
    task automatic capture(input bit e0_done);
        if (!e0_done) @(posedge clk);
        for (int k = 0; k < D; k++) begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            obs_an[k]  = ssd_an;
            obs_ctl[k] = ssd_ctl;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        repeat (2) @(negedge clk);
        checks++;
        if (ssd_an !== 4'hF || ssd_ctl !== 8'hFF) begin
            errors++;
            $display("FAIL reset_pins: an=%b ctl=%b, required an=1111 ctl=11111111", ssd_an, ssd_ctl);
        end
        checks++;
        if (frame_tick !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: tick=%b pending=%b, required 0 0", frame_tick, pending);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ssd_an !== 4'b1110 || ssd_ctl !== 8'hFF) begin
            errors++;
            $display("FAIL first_cycle: an=%b ctl=%b, required an=1110 ctl=11111111", ssd_an, ssd_ctl);
        end
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_tick("idle");
        capture(1'b0);
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs_an[k] !== e.an || obs_ctl[k] !== e.ctl) begin
                errors++;
                $display("FAIL idle slot%0d: an=%b ctl=%b, required an=%b ctl=%b", k, obs_an[k], obs_ctl[k], e.an, e.ctl);
            end
        end
        wait_tick("idle_period_start");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL tick_period: %0d cycles, required 16", n);
        end
    endtask

    task automatic test_lz;
        repeat (2) @(negedge clk);
        load = 1'b1;
        digits_in = {4'd0, 4'd0, 4'd4, 4'd2};
        dp_in = 4'b0000;
        push_frame(8'b00100101, 8'b10011001, 8'hFF, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL lz_pending: pending=%b, required 1", pending);
        end
        wait_tick("lz");
        capture(1'b0);
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs_an[k] !== e.an || obs_ctl[k] !== e.ctl) begin
                errors++;
                $display("FAIL lz slot%0d: an=%b ctl=%b, required an=%b ctl=%b", k, obs_an[k], obs_ctl[k], e.an, e.ctl);
            end
        end
    endtask

    task automatic test_dp_minus;
        @(negedge clk);
        load = 1'b1;
        digits_in = {4'd15, 4'd0, 4'd0, 4'd7};
        dp_in = 4'b0010;
        push_frame(8'b00011111, 8'b00000010, 8'b00000011, 8'b11111101);
        @(negedge clk);
        load = 1'b0;
        dp_in = 4'b0000;
        wait_tick("dp");
        capture(1'b0);
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs_an[k] !== e.an || obs_ctl[k] !== e.ctl) begin
                errors++;
                $display("FAIL dp slot%0d: an=%b ctl=%b, required an=%b ctl=%b", k, obs_an[k], obs_ctl[k], e.an, e.ctl);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        load = 1'b1;
        digits_in = 16'h0001;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending_first: pending=%b, required 1", pending);
        end
        @(negedge clk);
        load = 1'b1;
        digits_in = 16'h0009;
        push_frame(8'b00001001, 8'hFF, 8'hFF, 8'hFF);
        @(negedge clk);
        load = 1'b0;
        wait_tick("b2b");
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending_at_tick: pending=%b, required 1", pending);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending_after_tick: pending=%b, required 0", pending);
        end
        capture(1'b1);
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs_an[k] !== e.an || obs_ctl[k] !== e.ctl) begin
                errors++;
                $display("FAIL b2b slot%0d: an=%b ctl=%b, required an=%b ctl=%b", k, obs_an[k], obs_ctl[k], e.an, e.ctl);
            end
        end
    endtask

    task automatic test_load_at_tick;
        wait_tick("at_tick");
        load = 1'b1;
        digits_in = 16'h0005;
        dp_in = 4'b0001;
        push_frame(8'b01001000, 8'hFF, 8'hFF, 8'hFF);
        @(posedge clk);
        #1;
        load = 1'b0;
        dp_in = 4'b0000;
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL at_tick_pending: pending=%b, required 0", pending);
        end
        capture(1'b1);
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs_an[k] !== e.an || obs_ctl[k] !== e.ctl) begin
                errors++;
                $display("FAIL at_tick slot%0d: an=%b ctl=%b, required an=%b ctl=%b", k, obs_an[k], obs_ctl[k], e.an, e.ctl);
            end
        end
    endtask

    task automatic test_blank;
        int n;
        int bad;
        @(negedge clk);
        blank_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ssd_an !== 4'hF) begin
            errors++;
            $display("FAIL blank_next_cycle: an=%b, required 1111", ssd_an);
        end
        wait_tick("blank");
        n = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (ssd_an !== 4'hF) bad++;
        end while (!frame_tick && n < 40);
        checks++;
        if (n != 16 || bad != 0) begin
            errors++;
            $display("FAIL blank_scan: period=%0d lit_samples=%0d, required period=16 lit_samples=0", n, bad);
        end
        blank_en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ssd_an !== 4'b0111) begin
            errors++;
            $display("FAIL unblank: an=%b, required 0111", ssd_an);
        end
    endtask

    task automatic test_reset_midframe;
        repeat (5) @(negedge clk);
        load = 1'b1;
        digits_in = 16'h1111;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL rst_pending_before: pending=%b, required 1", pending);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ssd_an !== 4'hF || ssd_ctl !== 8'hFF || pending !== 1'b0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: an=%b ctl=%b pending=%b tick=%b, required 1111 11111111 0 0", ssd_an, ssd_ctl, pending, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_tick("after_reset");
        capture(1'b0);
        for (int k = 0; k < D; k++) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs_an[k] !== e.an || obs_ctl[k] !== e.ctl) begin
                errors++;
                $display("FAIL after_reset slot%0d: an=%b ctl=%b, required an=%b ctl=%b", k, obs_an[k], obs_ctl[k], e.an, e.ctl);
            end
        end
    endtask

    initial begin
        test_reset;
        test_lz;
        test_dp_minus;
        test_back_to_back;
        test_load_at_tick;
        test_blank;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
